// File: rtl/hwpe_stream_demux_burst_if.sv
// Valid/ready stream bundle used on both sides of the burst demultiplexer.
//   valid : source -> sink, beat present
//   ready : sink -> source, beat may transfer
//   data  : beat payload, DATA_WIDTH bits
//   strb  : byte enables, one per data byte
// master = stream source, slave = stream sink.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                      valid;
  logic                      ready;
  logic [DATA_WIDTH-1:0]     data;
  logic [DATA_WIDTH/8-1:0]   strb;

  modport master (output valid, output data, output strb, input ready);
  modport slave  (input valid, input data, input strb, output ready);

endinterface

// File: rtl/hwpe_stream_demux_burst.sv
// Burst stream demultiplexer: routes whole bursts from one input stream to one
// of NB_OUT_STREAMS outputs. Destination and length are captured on the first
// beat of a burst and held until its last beat is accepted.
//   clk_i  : clock, rising edge
//   rst_i  : synchronous reset, active high
//   sel_i  : destination index, sampled at burst start only
//   len_i  : burst length in beats, sampled at burst start (0 = 2^LEN_WIDTH)
//   in     : input stream (sink side)
//   out[]  : output streams (source side), data/strb broadcast
//   busy_o : a burst is locked
//   done_o : last beat of a burst accepted on in this cycle
//   err_o  : sticky, a burst started towards a non-existent output
module hwpe_stream_demux_burst #(
  parameter int unsigned NB_OUT_STREAMS = 2,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned LEN_WIDTH      = 16,
  parameter bit          REG_OUT        = 1'b1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [$clog2(NB_OUT_STREAMS)-1:0] sel_i,
  input  logic [LEN_WIDTH-1:0]              len_i,
  hwpe_stream_intf_stream.slave             in,
  hwpe_stream_intf_stream.master            out [NB_OUT_STREAMS-1:0],
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              err_o
);

  localparam int unsigned SEL_W  = $clog2(NB_OUT_STREAMS);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned PAD_N  = 2 ** SEL_W;
  localparam logic [SEL_W:0]       NB_EXT  = (SEL_W + 1)'(NB_OUT_STREAMS);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH - 1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e               state_r;
  state_e               state_nxt_s;
  logic [LEN_WIDTH-1:0] cnt_r;
  logic [SEL_W-1:0]     sel_r;
  logic                 err_r;

  logic [SEL_W-1:0]      dest_s;
  logic                  dest_ok_s;
  logic                  in_ready_s;
  logic                  in_hs_s;
  logic [PAD_N-1:0]      ready_pad_s;
  logic [NB_OUT_STREAMS-1:0] out_valid_s;
  logic [DATA_WIDTH-1:0] out_data_s;
  logic [STRB_W-1:0]     out_strb_s;

  // Ready vector padded to a power of two so any sel value indexes safely.
  for (genvar i = 0; i < NB_OUT_STREAMS; i++) begin : g_rdy
    assign ready_pad_s[i] = out[i].ready;
  end
  for (genvar i = NB_OUT_STREAMS; i < PAD_N; i++) begin : g_rdy_pad
    assign ready_pad_s[i] = 1'b0;
  end

  // Effective destination: live select until the burst is locked.
  always_comb begin
    if (state_r == BURST) begin
      dest_s = sel_r;
    end else begin
      dest_s = sel_i;
    end
    dest_ok_s = ({1'b0, dest_s} < NB_EXT);
  end

  assign in_hs_s  = in.valid & in_ready_s;
  assign in.ready = in_ready_s;

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: a length-1 burst never leaves IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_hs_s && (len_i != LEN_ONE)) begin
          state_nxt_s = BURST;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BURST: begin
        if (in_hs_s && (cnt_r == LEN_ONE)) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BURST;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: done marks acceptance of the final beat on the input side.
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_r)
      IDLE: begin
        busy_o = 1'b0;
        done_o = in_hs_s & (len_i == LEN_ONE);
      end
      BURST: begin
        busy_o = 1'b1;
        done_o = in_hs_s & (cnt_r == LEN_ONE);
      end
      default: begin
        busy_o = 1'b0;
        done_o = 1'b0;
      end
    endcase
  end

  // Beat counter, locked route and sticky error. len_i-1 wraps 0 to all ones,
  // which is exactly the remaining count for a 2^LEN_WIDTH burst.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r <= {LEN_WIDTH{1'b0}};
      sel_r <= {SEL_W{1'b0}};
      err_r <= 1'b0;
    end else if (in_hs_s) begin
      if (state_r == IDLE) begin
        cnt_r <= len_i - LEN_ONE;
        sel_r <= sel_i;
        err_r <= err_r | ~dest_ok_s;
      end else begin
        cnt_r <= cnt_r - LEN_ONE;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign err_o = err_r;

  if (REG_OUT) begin : g_reg
    logic                  full_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic [STRB_W-1:0]     strb_r;
    logic [SEL_W-1:0]      dest_r;
    logic                  drain_s;
    logic                  load_s;

    // Beats to an invalid destination are swallowed without touching the register.
    always_comb begin
      drain_s = full_r & ready_pad_s[dest_r];
      load_s  = in_hs_s & dest_ok_s;
      if (dest_ok_s) begin
        in_ready_s = ~full_r | drain_s;
      end else begin
        in_ready_s = 1'b1;
      end
    end

    // Single-entry output register; fill and drain may coincide.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        full_r <= 1'b0;
        data_r <= {DATA_WIDTH{1'b0}};
        strb_r <= {STRB_W{1'b0}};
        dest_r <= {SEL_W{1'b0}};
      end else if (load_s) begin
        full_r <= 1'b1;
        data_r <= in.data;
        strb_r <= in.strb;
        dest_r <= dest_s;
      end else if (drain_s) begin
        full_r <= 1'b0;
      end else begin
        full_r <= full_r;
      end
    end

    // Only the registered destination sees valid.
    always_comb begin
      for (int i = 0; i < NB_OUT_STREAMS; i++) begin
        out_valid_s[i] = full_r & (dest_r == SEL_W'(i));
      end
      out_data_s = data_r;
      out_strb_s = strb_r;
    end
  end else begin : g_comb
    // Pass-through: ready comes straight from the selected output.
    always_comb begin
      if (dest_ok_s) begin
        in_ready_s = ready_pad_s[dest_s];
      end else begin
        in_ready_s = 1'b1;
      end
      for (int i = 0; i < NB_OUT_STREAMS; i++) begin
        out_valid_s[i] = in.valid & dest_ok_s & (dest_s == SEL_W'(i));
      end
      out_data_s = in.data;
      out_strb_s = in.strb;
    end
  end

  for (genvar i = 0; i < NB_OUT_STREAMS; i++) begin : g_out
    assign out[i].valid = out_valid_s[i];
    assign out[i].data  = out_data_s;
    assign out[i].strb  = out_strb_s;
  end

endmodule

// File: tb/tb_hwpe_stream_demux_burst.sv
module tb_hwpe_stream_demux_burst;

  localparam int NB = 3;
  localparam int DW = 32;
  localparam int LW = 4;

  typedef struct packed {
    logic [1:0]  dest;
    logic [31:0] data;
    logic [3:0]  strb;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sel;
  logic [3:0] len;
  logic       busy_o, done_o, err_o;

  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) in_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) out_if [NB-1:0] ();

  logic [NB-1:0] o_valid;
  logic [NB-1:0] o_rdy;
  logic [31:0]   o_data [NB];
  logic [3:0]    o_strb [NB];

  for (genvar g = 0; g < NB; g++) begin : g_map
    assign o_valid[g]      = out_if[g].valid;
    assign o_data[g]       = out_if[g].data;
    assign o_strb[g]       = out_if[g].strb;
    assign out_if[g].ready = o_rdy[g];
  end

  hwpe_stream_demux_burst #(
    .NB_OUT_STREAMS(NB),
    .DATA_WIDTH    (DW),
    .LEN_WIDTH     (LW),
    .REG_OUT       (1'b1)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .sel_i (sel),
    .len_i (len),
    .in    (in_if),
    .out   (out_if),
    .busy_o(busy_o),
    .done_o(done_o),
    .err_o (err_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state and scoreboard.
  beat_t      q[$];
  bit         m_busy;
  logic [3:0] m_cnt;
  logic [1:0] m_sel;
  bit         m_err;
  int         rx_cnt [NB];
  int         done_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: check at negedge against the model, advance the model, return acceptance.
  task automatic tick(output bit acc);
    logic [1:0]    d;
    bit            ok, exp_ready, hs, exp_done;
    logic [NB-1:0] expv;
    beat_t         b;
    acc = 1'b0;
    @(negedge clk);
    if (!rst) begin
      d = m_busy ? m_sel : sel;
      ok = (int'(d) < NB);
      exp_ready = !ok || (q.size() == 0) || o_rdy[q[0].dest];
      chk("in_ready", 64'(in_if.ready), 64'(exp_ready));
      for (int i = 0; i < NB; i++) expv[i] = (q.size() != 0) && (int'(q[0].dest) == i);
      chk("out_valid", 64'(o_valid), 64'(expv));
      if (q.size() != 0) begin
        chk("out_data", 64'(o_data[q[0].dest]), 64'(q[0].data));
        chk("out_strb", 64'(o_strb[q[0].dest]), 64'(q[0].strb));
      end
      hs = in_if.valid && exp_ready;
      exp_done = hs && (m_busy ? (m_cnt == 4'd1) : (len == 4'd1));
      chk("done", 64'(done_o), 64'(exp_done));
      chk("busy", 64'(busy_o), 64'(m_busy));
      chk("err", 64'(err_o), 64'(m_err));
      for (int i = 0; i < NB; i++) if (o_valid[i] && o_rdy[i]) rx_cnt[i]++;
      if (done_o) done_cnt++;
      if ((q.size() != 0) && o_rdy[q[0].dest]) b = q.pop_front();
      if (hs) begin
        acc = 1'b1;
        if (ok) q.push_back('{dest: d, data: in_if.data, strb: in_if.strb});
        if (!m_busy) begin
          m_sel = sel;
          if (!ok) m_err = 1'b1;
          if (len != 4'd1) begin
            m_busy = 1'b1;
            m_cnt  = len - 4'd1;
          end
        end else begin
          m_cnt = m_cnt - 4'd1;
          if (m_cnt == 4'd0) m_busy = 1'b0;
        end
      end
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_busy = 1'b0;
      m_cnt  = 4'd0;
      m_sel  = 2'd0;
      m_err  = 1'b0;
    end
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input logic [1:0] s, input logic [3:0] l, input logic [31:0] dat);
    bit acc;
    int n;
    in_if.valid = 1'b1;
    in_if.data  = dat;
    in_if.strb  = dat[3:0];
    sel = s;
    len = l;
    n = 0;
    do begin
      tick(acc);
      n++;
    end while (!acc && n < 40);
    chk("send_accepted", 64'(acc), 64'(1));
  endtask

  task automatic idle(input int n);
    bit acc;
    in_if.valid = 1'b0;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NB; i++) rx_cnt[i] = 0;
    done_cnt = 0;
  endtask

  initial begin
    bit acc;
    rst = 1'b1;
    sel = 2'd0;
    len = 4'd1;
    in_if.valid = 1'b0;
    in_if.data  = 32'd0;
    in_if.strb  = 4'd0;
    o_rdy = '1;
    m_busy = 1'b0; m_cnt = 4'd0; m_sel = 2'd0; m_err = 1'b0;
    clear_counts();
    @(posedge clk); #1;
    tick(acc);
    rst = 1'b0;
    idle(1);
    chk("reset_busy", 64'(busy_o), 64'(0));
    chk("reset_err", 64'(err_o), 64'(0));
    chk("reset_valid", 64'(o_valid), 64'(0));

    // Burst of 4 to out[1].
    clear_counts();
    for (int k = 0; k < 4; k++) send(2'd1, 4'd4, 32'hA000_0010 + 32'(k));
    idle(2);
    chk("t1_rx1", 64'(rx_cnt[1]), 64'(4));
    chk("t1_rx0", 64'(rx_cnt[0] + rx_cnt[2]), 64'(0));
    chk("t1_done", 64'(done_cnt), 64'(1));

    // Burst of 3 to out[0] while sel toggles.
    clear_counts();
    for (int k = 0; k < 3; k++) send((k % 2 == 0) ? 2'd0 : 2'd1, 4'd3, 32'hB000_0020 + 32'(k));
    idle(2);
    chk("t2_rx0", 64'(rx_cnt[0]), 64'(3));
    chk("t2_rx1", 64'(rx_cnt[1]), 64'(0));

    // Back-to-back single-beat bursts alternating 0/1.
    clear_counts();
    for (int k = 0; k < 6; k++) send((k % 2 == 0) ? 2'd0 : 2'd1, 4'd1, 32'hC000_0030 + 32'(k));
    idle(2);
    chk("t3_done", 64'(done_cnt), 64'(6));
    chk("t3_rx0", 64'(rx_cnt[0]), 64'(3));
    chk("t3_rx1", 64'(rx_cnt[1]), 64'(3));

    // Back-pressure on out[2] mid-burst.
    clear_counts();
    send(2'd2, 4'd5, 32'hD000_0040);
    o_rdy[2] = 1'b0;
    in_if.valid = 1'b1;
    in_if.data  = 32'hD000_0041;
    in_if.strb  = 4'h1;
    for (int k = 0; k < 5; k++) begin
      tick(acc);
      chk("t4_stall_acc", 64'(acc), 64'(0));
      chk("t4_stall_data", 64'(o_data[2]), 64'h0000_0000_D000_0040);
    end
    o_rdy[2] = 1'b1;
    for (int k = 1; k < 5; k++) send(2'd2, 4'd5, 32'hD000_0040 + 32'(k));
    idle(2);
    chk("t4_rx2", 64'(rx_cnt[2]), 64'(5));
    chk("t4_done", 64'(done_cnt), 64'(1));

    // Invalid destination: beats dropped, sticky error.
    clear_counts();
    for (int k = 0; k < 2; k++) send(2'd3, 4'd2, 32'hE000_0050 + 32'(k));
    idle(1);
    chk("t5_err", 64'(err_o), 64'(1));
    chk("t5_rx", 64'(rx_cnt[0] + rx_cnt[1] + rx_cnt[2]), 64'(0));
    for (int k = 0; k < 2; k++) send(2'd0, 4'd2, 32'hE000_0060 + 32'(k));
    idle(2);
    chk("t5_err_sticky", 64'(err_o), 64'(1));
    chk("t5_rx0", 64'(rx_cnt[0]), 64'(2));

    // len 0 encodes 16 beats.
    clear_counts();
    for (int k = 0; k < 16; k++) send(2'd2, 4'd0, 32'hF000_0070 + 32'(k));
    idle(2);
    chk("t6_rx2", 64'(rx_cnt[2]), 64'(16));
    chk("t6_done", 64'(done_cnt), 64'(1));

    // Reset during beat 2 of a 5-beat burst.
    send(2'd1, 4'd5, 32'h1100_0080);
    rst = 1'b1;
    in_if.data = 32'h1100_0081;
    tick(acc);
    rst = 1'b0;
    in_if.valid = 1'b0;
    tick(acc);
    chk("t7_busy", 64'(busy_o), 64'(0));
    chk("t7_valid", 64'(o_valid), 64'(0));
    chk("t7_err", 64'(err_o), 64'(0));
    clear_counts();
    for (int k = 0; k < 2; k++) send(2'd0, 4'd2, 32'h1100_0090 + 32'(k));
    idle(2);
    chk("t7_rx0", 64'(rx_cnt[0]), 64'(2));
    chk("t7_done", 64'(done_cnt), 64'(1));
    chk("sb_empty", 64'(q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
